// File: rtl/adder_job_arbiter_pkg.sv
// Shared definitions for the adder job arbiter.
//   state_t            : job sequencer states
//   REG_*_OFFSET       : AXI-lite register map of the adder slave
//   RESP_ERR           : value of bresp/rresp that flags a slave error
package adder_job_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR_A = 3'd1,
    ST_WR_B = 3'd2,
    ST_RD   = 3'd3,
    ST_RSP  = 3'd4
  } state_t;

  localparam int unsigned REG_A_OFFSET   = 32'h00;
  localparam int unsigned REG_B_OFFSET   = 32'h04;
  localparam int unsigned REG_SUM_OFFSET = 32'h08;

  localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/adder_rr_arbiter.sv
// Two-way round-robin grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request
//   accept     : the current grant is being taken this cycle
//   grant      : one-hot grant (combinational), zero when no request
module adder_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // Index of the requester that wins a tie; after any grant it points at
  // the other requester.
  logic prio;

  always_comb begin
    grant = '0;
    if (req == 2'b11) begin
      grant[prio] = 1'b1;
    end else begin
      grant = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (accept && (grant != 2'b00)) begin
      prio <= grant[0];
    end
  end

endmodule

// File: rtl/adder_job_arbiter.sv
// Arbitrates add jobs from two requesters onto an AXI-lite adder slave.
// A job writes operand A to 0x00, operand B to 0x04, reads the sum at 0x08
// and returns it to the granted requester.
//   m1_axi_aclk/aresetn   : clock, asynchronous active-low reset
//   req_valid/req_a/req_b : job requests, operands packed per requester
//   req_ready             : one-cycle one-hot accept pulse
//   rsp_valid/rsp_data/rsp_err/rsp_ready : job result handshake
//   m1_axi_*              : AXI-lite master to the adder slave
module adder_job_arbiter
  import adder_job_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_aresetn,
  input  logic [1:0]              req_valid,
  input  logic [2*DATA_WIDTH-1:0] req_a,
  input  logic [2*DATA_WIDTH-1:0] req_b,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_err,
  input  logic                    rsp_ready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic                    m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic                    m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  state_t                state, state_d;
  logic [1:0]            grant, owner;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic                  aw_done, w_done, ar_done;
  logic                  accept, in_wr;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  b_err, r_err;

  adder_rr_arbiter u_arb (
    .clk    (m1_axi_aclk),
    .rst_n  (m1_axi_aresetn),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  // Handshakes are derived from state and done flags rather than from the
  // output ports so the output block can stay a pure function of state.
  always_comb begin
    accept = (state == ST_IDLE) && (req_valid != 2'b00);
    in_wr  = (state == ST_WR_A) || (state == ST_WR_B);
    aw_hs  = in_wr && !aw_done && m1_axi_awready;
    w_hs   = in_wr && !w_done && m1_axi_wready;
    b_hs   = in_wr && m1_axi_bvalid;
    ar_hs  = (state == ST_RD) && !ar_done && m1_axi_arready;
    r_hs   = (state == ST_RD) && m1_axi_rvalid;
    b_err  = (m1_axi_bresp == RESP_ERR);
    r_err  = (m1_axi_rresp == RESP_ERR);
  end

  always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
    if (!m1_axi_aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d        = state;
    m1_axi_awvalid = in_wr && !aw_done;
    m1_axi_wvalid  = in_wr && !w_done;
    m1_axi_bready  = in_wr;
    m1_axi_awaddr  = (state == ST_WR_B) ? ADDR_WIDTH'(REG_B_OFFSET) : ADDR_WIDTH'(REG_A_OFFSET);
    m1_axi_wdata   = (state == ST_WR_B) ? op_b : op_a;
    m1_axi_wstrb   = '1;
    m1_axi_arvalid = (state == ST_RD) && !ar_done;
    m1_axi_araddr  = ADDR_WIDTH'(REG_SUM_OFFSET);
    m1_axi_rready  = (state == ST_RD);
    rsp_valid      = (state == ST_RSP) ? owner : '0;
    case (state)
      ST_IDLE: if (accept) state_d = ST_WR_A;
      ST_WR_A: if (b_hs) state_d = b_err ? ST_RSP : ST_WR_B;
      ST_WR_B: if (b_hs) state_d = b_err ? ST_RSP : ST_RD;
      ST_RD:   if (r_hs) state_d = ST_RSP;
      ST_RSP:  if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
    if (!m1_axi_aresetn) begin
      req_ready <= '0;
      owner     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      ar_done   <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= accept ? grant : '0;
      if (accept) begin
        owner <= grant;
        op_a  <= grant[1] ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
        op_b  <= grant[1] ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
      end
      // Per-phase done flags restart on every state change so WR_B reissues
      // both address and data channels.
      if (state_d != state) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        ar_done <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
        if (ar_hs) ar_done <= 1'b1;
      end
      if (b_hs && b_err) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end else if (r_hs) begin
        rsp_data <= r_err ? '0 : m1_axi_rdata;
        rsp_err  <= r_err;
      end
    end
  end

endmodule
